result_uart_sequencer: RTL and testbench
========================================

Name: result_uart_sequencer

Overview:
- Sits between the compute block and the UART transmitter.
- Watches the compute block's running flag. On each run-to-idle transition it captures a NUM_BYTES-wide result word and serialises it MSB byte first into the UART.
- Uses the UART's is_transmitting flag as the per-byte handshake.
- Replaces the single-byte, fire-once transmit logic with a re-armable, multi-byte, flow-controlled sender.

Parameters:
- NUM_BYTES, 4: number of result bytes sent per run; legal range 1..16.
- START_TIMEOUT, 1023: maximum cycles to wait for is_transmitting to rise after a transmit pulse; legal range 1..65535.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- program_is_running  input  1  high while the compute block is executing
- result  input  8*NUM_BYTES  compute result; sampled only at the trigger edge
- is_transmitting  input  1  UART busy flag
- transmit  output  1  one-cycle strobe to the UART
- tx_byte  output  8  byte presented to the UART; held stable from the strobe until the byte completes
- busy  output  1  high whenever state is not IDLE
- overrun  output  1  sticky; a trigger arrived while busy
- timeout_err  output  1  sticky; is_transmitting failed to rise within START_TIMEOUT

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; transmit=0, tx_byte=0, busy=0, overrun=0, timeout_err=0.
  - run_q (registered program_is_running) = 0, so a low level out of reset never triggers.
- Trigger: run_q==1 && program_is_running==0, i.e. a falling edge sampled at a clk edge.
- IDLE:
  - On trigger: latch result into shift register sreg, clear byte counter cnt, go to STROBE.
  - No other action.
- STROBE (exactly one cycle):
  - transmit=1; tx_byte=sreg[8*NUM_BYTES-1 -: 8].
  - Clear the timeout counter; go to WAIT_RISE.
- WAIT_RISE:
  - transmit=0.
  - If is_transmitting==1, go to WAIT_FALL.
  - Else if the timeout counter reaches START_TIMEOUT: set timeout_err=1 and go to NEXT (the byte is treated as lost).
- WAIT_FALL: when is_transmitting==0, go to NEXT.
- NEXT:
  - sreg shifts left by 8; cnt increments.
  - If cnt was NUM_BYTES-1, go to IDLE (or to CKSUM when the feature is enabled); otherwise go to STROBE.
- Latency:
  - transmit is high in the cycle after the trigger edge.
  - Gap between the end of one byte (is_transmitting falls) and the next strobe is exactly 2 clk cycles (NEXT, then STROBE).
- Trigger while busy: ignored; overrun=1 and stays set until reset. The transfer in progress continues unaffected.
- result changes after capture: no effect.
- program_is_running toggling during a transfer: only updates run_q; never aborts the transfer.
- rst_n asserted mid-transfer: immediate return to IDLE with all outputs at reset values. A byte already inside the UART may still complete, but no further strobes are issued.
- tx_byte: holds its last value in IDLE.
- Counter widths: cnt is clog2(NUM_BYTES+1) bits; the timeout counter is 16 bits and saturates.

Optional Feature:
- Macro: RESULT_CHECKSUM_EN.
- Defined:
  - Adds a CKSUM state after the last data byte.
  - Sends one extra byte equal to the XOR of all NUM_BYTES data bytes, accumulated as each byte is strobed, using the same STROBE/WAIT_RISE/WAIT_FALL handshake.
  - The accumulator clears on trigger.
  - A byte lost to timeout is still included in the XOR.
- Undefined: no CKSUM state and no accumulator logic; frames are exactly NUM_BYTES bytes.

Test Plan:
- Basic frame (NUM_BYTES=4, result=32'hDEADBEEF, UART model asserts is_transmitting 1 cycle after strobe for 100 cycles):
  - run high→low produces 4 single-cycle strobes with tx_byte DE, AD, BE, EF.
  - Each strobe comes 2 cycles after the previous is_transmitting fall.
  - busy drops after the last byte.
- Reset-low start: hold program_is_running=0 from reset for 1000 cycles → no transmit, busy=0. A subsequent 0→1→0 pulse produces one frame.
- Overrun: second falling edge during byte 2 → overrun=1; exactly 4 bytes sent; no second frame.
- Timeout (START_TIMEOUT=15, UART model never raises is_transmitting):
  - timeout_err=1 after 15 cycles in WAIT_RISE.
  - All 4 strobes still issued; busy returns to 0.
- Async reset mid-frame: assert rst_n low during WAIT_FALL of byte 1 → all outputs 0 within the same cycle; no further strobes after release.
- RESULT_CHECKSUM_EN, result=32'h01020304 → 5 bytes: 01 02 03 04 04.

Source files
------------

// File: rtl/result_uart_sequencer.sv
// -----------------------------------------------------------------------------
// result_uart_sequencer
//
// Purpose:
//   Watches the compute block's running flag. On every run-to-idle transition
//   it captures a NUM_BYTES-wide result word and sends it to the UART MSB byte
//   first. The UART's is_transmitting flag is the per-byte handshake. A
//   watchdog limits how long we wait for the UART to go busy after a strobe.
//
// Optional feature (macro RESULT_CHECKSUM_EN):
//   Appends one extra byte, the XOR of all data bytes in the frame.
//
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   program_is_running  high while the compute block is executing
//   result              compute result, sampled only at the trigger edge
//   is_transmitting     UART busy flag
//   transmit            one-cycle strobe to the UART
//   tx_byte             byte presented to the UART (held until the next strobe)
//   busy                high whenever the sequencer is not idle
//   overrun             sticky: a trigger arrived while busy
//   timeout_err         sticky: is_transmitting failed to rise in time
// -----------------------------------------------------------------------------
module result_uart_sequencer #(
   parameter int NUM_BYTES     = 4,
   parameter int START_TIMEOUT = 1023
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   program_is_running,
   input  logic [8*NUM_BYTES-1:0] result,
   input  logic                   is_transmitting,
   output logic                   transmit,
   output logic [7:0]             tx_byte,
   output logic                   busy,
   output logic                   overrun,
   output logic                   timeout_err
);

   localparam int W  = 8 * NUM_BYTES;
   localparam int CW = $clog2(NUM_BYTES + 1);
   // Last WAIT_RISE cycle index; the byte is abandoned after START_TIMEOUT cycles.
   localparam logic [15:0] TMO_LAST = 16'(START_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STROBE,
      S_WAIT_RISE,
      S_WAIT_FALL,
      S_NEXT
`ifdef RESULT_CHECKSUM_EN
      ,S_CKSUM
`endif
   } state_e;

   state_e           state_q, state_d;
   logic             run_q;
   logic [W-1:0]     sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [15:0]      tmo_q, tmo_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             overrun_q, overrun_d;
   logic             tmo_err_q, tmo_err_d;
   logic             trigger;
`ifdef RESULT_CHECKSUM_EN
   logic [7:0]       acc_q, acc_d;
   logic             ck_q, ck_d;   // checksum byte is the one in flight
`endif

   assign trigger = run_q & ~program_is_running;

   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      tx_byte_d = tx_byte_q;
      overrun_d = overrun_q;
      tmo_err_d = tmo_err_q;
`ifdef RESULT_CHECKSUM_EN
      acc_d     = acc_q;
      ck_d      = ck_q;
`endif

      if (trigger && state_q != S_IDLE) overrun_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               sreg_d  = result;
               cnt_d   = '0;
               state_d = S_STROBE;
`ifdef RESULT_CHECKSUM_EN
               acc_d   = '0;
               ck_d    = 1'b0;
`endif
            end
         end
         S_STROBE: begin
            tmo_d   = '0;
            state_d = S_WAIT_RISE;
`ifdef RESULT_CHECKSUM_EN
            // Accumulate at strobe time so a byte lost to timeout still counts.
            acc_d   = acc_q ^ tx_byte_q;
`endif
         end
         S_WAIT_RISE: begin
            if (is_transmitting) begin
               state_d = S_WAIT_FALL;
            end else if (tmo_q >= TMO_LAST) begin
               tmo_err_d = 1'b1;
               state_d   = S_NEXT;
            end else if (tmo_q != 16'hFFFF) begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_WAIT_FALL: begin
            if (!is_transmitting) state_d = S_NEXT;
         end
         S_NEXT: begin
`ifdef RESULT_CHECKSUM_EN
            if (ck_q) begin
               state_d = S_IDLE;
            end else
`endif
            begin
               sreg_d = sreg_q << 8;
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == CW'(NUM_BYTES - 1)) begin
`ifdef RESULT_CHECKSUM_EN
                  state_d = S_CKSUM;
`else
                  state_d = S_IDLE;
`endif
               end else begin
                  state_d = S_STROBE;
               end
            end
         end
`ifdef RESULT_CHECKSUM_EN
         // Acts as the strobe cycle for the checksum byte.
         S_CKSUM: begin
            ck_d    = 1'b1;
            tmo_d   = '0;
            state_d = S_WAIT_RISE;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Load tx_byte on entry to a strobe cycle so it is valid while transmit
      // is high and stays put until the next strobe (and through IDLE).
      if (state_d == S_STROBE) tx_byte_d = sreg_d[W-1 -: 8];
`ifdef RESULT_CHECKSUM_EN
      if (state_d == S_CKSUM) tx_byte_d = acc_q;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         run_q     <= 1'b0;
         sreg_q    <= '0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         tx_byte_q <= '0;
         overrun_q <= 1'b0;
         tmo_err_q <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
         acc_q     <= '0;
         ck_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         run_q     <= program_is_running;
         sreg_q    <= sreg_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         tx_byte_q <= tx_byte_d;
         overrun_q <= overrun_d;
         tmo_err_q <= tmo_err_d;
`ifdef RESULT_CHECKSUM_EN
         acc_q     <= acc_d;
         ck_q      <= ck_d;
`endif
      end
   end

`ifdef RESULT_CHECKSUM_EN
   assign transmit = (state_q == S_STROBE) || (state_q == S_CKSUM);
`else
   assign transmit = (state_q == S_STROBE);
`endif
   assign tx_byte     = tx_byte_q;
   assign busy        = (state_q != S_IDLE);
   assign overrun     = overrun_q;
   assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_result_uart_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for result_uart_sequencer. A cycle-level UART responder raises
// is_transmitting a programmable delay after each strobe; a byte queue holds
// the expected frame, and timing is checked against the frame rules
// (trigger->strobe = 1, fall->strobe = 2, timeout spacing = START_TIMEOUT+2).
// -----------------------------------------------------------------------------
module tb_result_uart_sequencer;
   localparam int NB  = 4;
   localparam int TMO = 15;

   logic            clk = 0, rst_n = 0, pir = 0, is_tx = 0;
   logic [8*NB-1:0] result = '0;
   logic            transmit, busy, overrun, timeout_err;
   logic [7:0]      tx_byte;

   always #5 clk = ~clk;

   result_uart_sequencer #(.NUM_BYTES(NB), .START_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .program_is_running(pir), .result(result),
      .is_transmitting(is_tx), .transmit(transmit), .tx_byte(tx_byte),
      .busy(busy), .overrun(overrun), .timeout_err(timeout_err));

   int n_chk = 0, n_err = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference state
   logic [7:0] exp_q[$];
   logic [7:0] last_byte = 0;
   int  cyc = 0, trig_cyc = 0, last_fall = -100, prev_strobe = -100, end_cyc = -100;
   int  n_strobe = 0, u_dly = 0, u_len = 0, d_cur = 1, l_cur = 4;
   bit  first_pend = 0, frame_on = 0, never = 0;

   // Monitor + UART responder, evaluated 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (u_dly > 0) begin
         u_dly--;
         if (u_dly == 0) begin is_tx = 1; u_len = l_cur; end
      end else if (is_tx) begin
         u_len--;
         if (u_len == 0) begin
            is_tx = 0;
            last_fall = cyc;
            if (frame_on && exp_q.size() == 0) begin end_cyc = cyc; frame_on = 0; end
         end
      end
      if (cyc == prev_strobe + 1) chk("strobe_width", 32'(transmit), 0);
      if (transmit) begin
         n_strobe++;
         if (exp_q.size() == 0) begin
            chk("spurious_strobe", 32'(transmit), 0);
         end else begin
            last_byte = exp_q.pop_front();
            chk("tx_byte", 32'(tx_byte), 32'(last_byte));
            if (first_pend) chk("trig_latency", 32'(cyc - trig_cyc), 1);
            else if (never) chk("timeout_spacing", 32'(cyc - prev_strobe), TMO + 2);
            else chk("fall_to_strobe", 32'(cyc - last_fall), 2);
            first_pend = 0;
            if (never && exp_q.size() == 0 && frame_on) begin end_cyc = cyc + TMO; frame_on = 0; end
         end
         prev_strobe = cyc;
         if (!never) u_dly = d_cur;
      end else begin
         chk("tx_hold", 32'(tx_byte), 32'(last_byte));
      end
      if (cyc == end_cyc + 1) chk("busy_tail", 32'(busy), 1);
      if (cyc == end_cyc + 2) chk("busy_end", 32'(busy), 0);
   end

   task automatic start_frame(input logic [8*NB-1:0] res, input int d, input int l, input bit nv);
      logic [7:0] x;
      x = 0;
      @(negedge clk);
      result = res; d_cur = d; l_cur = l; never = nv; pir = 1;
      @(negedge clk);
      for (int i = NB - 1; i >= 0; i--) begin
         exp_q.push_back(res[8*i +: 8]);
         x ^= res[8*i +: 8];
      end
`ifdef RESULT_CHECKSUM_EN
      exp_q.push_back(x);
`endif
      frame_on = 1; first_pend = 1; trig_cyc = cyc; pir = 0;
      @(negedge clk);
      result = $urandom;   // must not affect the captured frame
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((frame_on || cyc <= end_cyc + 2) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("frame_done", 32'(frame_on), 0);
      chk("queue_empty", 32'(exp_q.size()), 0);
   endtask

   initial begin
      int s0, t;
      #2;
      chk("rst_transmit", 32'(transmit), 0);
      chk("rst_tx_byte", 32'(tx_byte), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_timeout", 32'(timeout_err), 0);
      repeat (2) @(negedge clk);
      rst_n = 1;

      // Low level out of reset must never trigger.
      repeat (1000) @(negedge clk);
      chk("idle_no_strobe", 32'(n_strobe), 0);
      chk("idle_busy", 32'(busy), 0);

      // Basic frame, slow UART.
      start_frame(32'hDEADBEEF, 1, 100, 0);
      wait_idle();
      start_frame(32'h01020304, 2, 5, 0);
      wait_idle();

      // Randomised frames and UART timing.
      for (int i = 0; i < 6; i++) begin
         start_frame($urandom, $urandom_range(1, 6), $urandom_range(1, 20), 0);
         wait_idle();
         repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      chk("no_overrun_yet", 32'(overrun), 0);

      // Overrun: second falling edge while byte 2 is in flight.
      s0 = n_strobe;
      start_frame($urandom, 2, 10, 0);
      t = 0;
      while (n_strobe < s0 + 2 && t < 500) begin @(negedge clk); t++; end
      chk("ovr_reach_byte2", 32'(n_strobe >= s0 + 2), 1);
      pir = 1; @(negedge clk); pir = 0; @(negedge clk);
      chk("overrun_set", 32'(overrun), 1);
      wait_idle();
      repeat (60) @(negedge clk);
`ifdef RESULT_CHECKSUM_EN
      chk("ovr_byte_count", 32'(n_strobe - s0), NB + 1);
`else
      chk("ovr_byte_count", 32'(n_strobe - s0), NB);
`endif
      chk("overrun_sticky", 32'(overrun), 1);
      chk("no_timeout_yet", 32'(timeout_err), 0);

      // Timeout: UART never responds.
      start_frame($urandom, 1, 1, 1);
      wait_idle();
      chk("timeout_set", 32'(timeout_err), 1);
      never = 0;
      repeat (5) @(negedge clk);

      // Async reset during WAIT_FALL of byte 1.
      start_frame($urandom, 1, 40, 0);
      t = 0;
      while (!is_tx && t < 100) begin @(negedge clk); t++; end
      chk("rst_mid_reach", 32'(is_tx), 1);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 0; exp_q.delete(); frame_on = 0; last_byte = 0;
      #1;
      chk("mid_rst_transmit", 32'(transmit), 0);
      chk("mid_rst_tx_byte", 32'(tx_byte), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_overrun", 32'(overrun), 0);
      chk("mid_rst_timeout", 32'(timeout_err), 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      s0 = n_strobe;
      repeat (200) @(negedge clk);
      chk("post_rst_no_strobe", 32'(n_strobe - s0), 0);
      chk("post_rst_busy", 32'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
